// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// alu_cmd_driver : sequential initiator for the combinational ALU datapath.
// Registers a command onto the datapath, waits SETTLE cycles, returns the result.
// Revision: 1.0
// ============================================================================
module alu_cmd_driver #(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_alucontrol,
    input  logic [1:0]       cmd_bshift,
    input  logic             cmd_select,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       alu_bshift,
    output logic             alu_select,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [3:0]       c_SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_settle;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_control;
    logic [1:0]       r_alu_bshift;
    logic             r_alu_select;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic [CNT_W-1:0] r_txn_count;

    logic w_cmd_fire;
    logic w_settle_done;
    logic w_capture;
    logic w_rsp_fire;

    assign w_cmd_fire    = cmd_valid && (r_state == S_IDLE);
    assign w_settle_done = (r_settle == 4'd0);
    assign w_capture     = (r_state == S_WAIT) && w_settle_done;
    assign w_rsp_fire    = (r_state == S_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_fire)    w_next = S_WAIT;
            S_WAIT:  if (w_settle_done) w_next = S_RESP;
            S_RESP:  if (w_rsp_fire)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath operands change only on acceptance so the ALU inputs never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_alu_bshift  <= '0;
            r_alu_select  <= 1'b0;
        end else if (w_cmd_fire) begin
            r_alu_a       <= cmd_a;
            r_alu_b       <= cmd_b;
            r_alu_control <= cmd_alucontrol;
            r_alu_bshift  <= cmd_bshift;
            r_alu_select  <= cmd_select;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_settle <= '0;
        end else if (w_cmd_fire) begin
            r_settle <= c_SETTLE_LOAD;
        end else if ((r_state == S_WAIT) && !w_settle_done) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else if (w_capture) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= alu_flags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txn_count <= '0;
        end else if (w_rsp_fire) begin
            r_txn_count <= r_txn_count + c_CNT_ONE;
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;
    assign alu_bshift  = r_alu_bshift;
    assign alu_select  = r_alu_select;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign txn_count   = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// Bench for alu_cmd_driver: two instances (SETTLE=1 and SETTLE=3) with XOR datapath stubs,
// a timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       cv   [2];
    logic [4:0] ca   [2];
    logic [4:0] cb   [2];
    logic [2:0] cc   [2];
    logic [1:0] cbs  [2];
    logic       csel [2];
    logic       rr   [2];
    logic [4:0] pert;

    logic       rdy0, busy0, rv0, asel0;
    logic [4:0] aa0, ab0, rres0;
    logic [2:0] ac0;
    logic [1:0] abs0;
    logic [3:0] rflg0;
    logic [7:0] cnt0;
    logic       rdy1, busy1, rv1, asel1;
    logic [4:0] aa1, ab1, rres1;
    logic [2:0] ac1;
    logic [1:0] abs1;
    logic [3:0] rflg1;
    logic [7:0] cnt1;

    // Datapath stubs; instance 1 gets an extra bench-controlled disturbance term.
    logic [4:0] res0, res1;
    logic [3:0] flg0, flg1;
    assign res0 = aa0 ^ ab0;
    assign flg0 = {(res0 == 5'd0), 3'b000};
    assign res1 = aa1 ^ ab1 ^ pert;
    assign flg1 = {(res1 == 5'd0), 3'b000};

    alu_cmd_driver #(.WIDTH(5), .SETTLE(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cv[0]), .cmd_ready(rdy0),
        .cmd_a(ca[0]), .cmd_b(cb[0]), .cmd_alucontrol(cc[0]),
        .cmd_bshift(cbs[0]), .cmd_select(csel[0]),
        .alu_a(aa0), .alu_b(ab0), .alu_control(ac0),
        .alu_bshift(abs0), .alu_select(asel0),
        .alu_result(res0), .alu_flags(flg0),
        .rsp_valid(rv0), .rsp_ready(rr[0]),
        .rsp_result(rres0), .rsp_flags(rflg0),
        .busy(busy0), .txn_count(cnt0)
    );

    alu_cmd_driver #(.WIDTH(5), .SETTLE(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cv[1]), .cmd_ready(rdy1),
        .cmd_a(ca[1]), .cmd_b(cb[1]), .cmd_alucontrol(cc[1]),
        .cmd_bshift(cbs[1]), .cmd_select(csel[1]),
        .alu_a(aa1), .alu_b(ab1), .alu_control(ac1),
        .alu_bshift(abs1), .alu_select(asel1),
        .alu_result(res1), .alu_flags(flg1),
        .rsp_valid(rv1), .rsp_ready(rr[1]),
        .rsp_result(rres1), .rsp_flags(rflg1),
        .busy(busy1), .txn_count(cnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks accept time and decides response timing from elapsed cycles.
    logic       m_busy [2];
    logic       m_rv   [2];
    logic [4:0] m_a    [2];
    logic [4:0] m_b    [2];
    logic [2:0] m_c    [2];
    logic [1:0] m_bs   [2];
    logic       m_sel  [2];
    logic [4:0] m_res  [2];
    logic [3:0] m_flg  [2];
    logic [7:0] m_cnt  [2];
    int         m_acc  [2];
    int         m_cyc;
    logic [4:0] m_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc = 0;
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0; m_rv[d] = 1'b0;
                m_a[d] = '0; m_b[d] = '0; m_c[d] = '0; m_bs[d] = '0; m_sel[d] = 1'b0;
                m_res[d] = '0; m_flg[d] = '0; m_cnt[d] = '0; m_acc[d] = 0;
            end
        end else begin
            m_cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (cv[d]) begin
                        m_a[d] = ca[d]; m_b[d] = cb[d]; m_c[d] = cc[d];
                        m_bs[d] = cbs[d]; m_sel[d] = csel[d];
                        m_busy[d] = 1'b1; m_acc[d] = m_cyc;
                    end
                end else if (!m_rv[d]) begin
                    if (m_cyc - m_acc[d] == ((d == 0) ? 1 : 3)) begin
                        m_r = m_a[d] ^ m_b[d] ^ ((d == 1) ? pert : 5'd0);
                        m_res[d] = m_r;
                        m_flg[d] = {(m_r == 5'd0), 3'b000};
                        m_rv[d]  = 1'b1;
                    end
                end else if (rr[d]) begin
                    m_rv[d] = 1'b0; m_busy[d] = 1'b0;
                    m_cnt[d] = m_cnt[d] + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model dut0",
            {rdy0, busy0, rv0, aa0, ab0, ac0, abs0, asel0, rres0, rflg0, cnt0},
            {!m_busy[0], m_busy[0], m_rv[0], m_a[0], m_b[0], m_c[0], m_bs[0], m_sel[0],
             m_res[0], m_flg[0], m_cnt[0]});
        chk("model dut1",
            {rdy1, busy1, rv1, aa1, ab1, ac1, abs1, asel1, rres1, rflg1, cnt1},
            {!m_busy[1], m_busy[1], m_rv[1], m_a[1], m_b[1], m_c[1], m_bs[1], m_sel[1],
             m_res[1], m_flg[1], m_cnt[1]});
    end

    int tcyc = 0;
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            tcyc++;
        end
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int last;
        int g;
        reset_n = 1'b1;
        pert    = '0;
        for (int d = 0; d < 2; d++) begin
            cv[d] = 0; ca[d] = 0; cb[d] = 0; cc[d] = 0; cbs[d] = 0; csel[d] = 0; rr[d] = 0;
        end
        #1 reset_n = 1'b0;
        tick(2);
        chk("reset cmd_ready", rdy0, 1);
        chk("reset rsp_valid", rv0, 0);
        chk("reset alu_a", aa1, 0);
        chk("reset txn", cnt0, 0);
        reset_n = 1'b1;
        tick(1);

        // Single command on the SETTLE=1 instance
        ca[0] = 5'h15; cb[0] = 5'h0A; cc[0] = 3'd2; cbs[0] = 2'd1; csel[0] = 1'b1;
        rr[0] = 1'b1; cv[0] = 1'b1;
        tick(1);
        cv[0] = 1'b0;
        chk("single alu_a", aa0, 5'h15);
        chk("single ready low", rdy0, 0);
        tick(1);
        chk("single rsp_valid", rv0, 1);
        chk("single result", rres0, 5'h1F);
        chk("single flags", rflg0, 4'h0);
        tick(1);
        chk("single txn", cnt0, 1);

        // Backpressure with a second command held by the producer
        rr[0] = 1'b0; ca[0] = 5'h07; cb[0] = 5'h07; cv[0] = 1'b1;
        tick(1);
        ca[0] = 5'h03; cb[0] = 5'h01;
        tick(1);
        chk("bp result", rres0, 5'h00);
        chk("bp flags", rflg0, 4'h8);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("bp hold valid", rv0, 1);
            chk("bp hold flags", rflg0, 4'h8);
            chk("bp ready low", rdy0, 0);
            chk("bp alu_a held", aa0, 5'h07);
        end
        rr[0] = 1'b1;
        tick(1);
        chk("bp released ready", rdy0, 1);
        chk("bp no early accept", aa0, 5'h07);
        chk("bp txn", cnt0, 2);
        tick(1);
        chk("bp second accepted", aa0, 5'h03);
        cv[0] = 1'b0;
        tick(2);
        chk("bp second txn", cnt0, 3);

        // SETTLE=3: datapath result moves after accept; sample comes from accept+3
        rr[1] = 1'b1; ca[1] = 5'h04; cb[1] = 5'h01; cv[1] = 1'b1;
        tick(1);
        cv[1] = 1'b0; pert = 5'h10;
        chk("s3 rv +0", rv1, 0);
        tick(1);
        chk("s3 rv +1", rv1, 0);
        tick(1);
        chk("s3 rv +2", rv1, 0);
        tick(1);
        chk("s3 rv +3", rv1, 1);
        chk("s3 result", rres1, 5'h15);
        rr[1] = 1'b0; pert = 5'h00;
        tick(1);
        chk("s3 result held", rres1, 5'h15);
        rr[1] = 1'b1;
        tick(1);
        chk("s3 txn", cnt1, 1);

        // Reset one cycle after accept on the SETTLE=3 instance
        ca[1] = 5'h02; cb[1] = 5'h02; cv[1] = 1'b1;
        tick(1);
        cv[1] = 1'b0;
        tick(1);
        reset_n = 1'b0;
        #1;
        chk("midrst ready", rdy1, 1);
        chk("midrst busy", busy1, 0);
        chk("midrst valid", rv1, 0);
        chk("midrst alu_a", aa1, 0);
        chk("midrst txn", cnt1, 0);
        tick(3);
        reset_n = 1'b1;
        tick(3);
        chk("midrst no rsp", rv1, 0);
        chk("midrst txn stays", cnt1, 0);
        ca[1] = 5'h09; cb[1] = 5'h03; cv[1] = 1'b1;
        tick(1);
        cv[1] = 1'b0;
        tick(3);
        chk("post-rst rsp", rv1, 1);
        chk("post-rst result", rres1, 5'h0A);
        tick(1);
        chk("post-rst txn", cnt1, 1);

        // 256 back-to-back commands: period SETTLE+2 and counter wrap
        rr[0] = 1'b1; cv[0] = 1'b1; last = tcyc;
        for (int i = 0; i < 256; i++) begin
            g = 0;
            while (!rdy0 && g < 10) begin
                tick(1);
                g++;
            end
            if (g >= 10) begin
                chk("wrap ready timeout", 0, 1);
                break;
            end
            if (i > 0) chk("wrap period", 64'(tcyc - last), 3);
            if (i == 255) chk("txn before wrap", cnt0, 8'd255);
            last = tcyc;
            ca[0] = 5'(i); cb[0] = 5'(i * 7);
            tick(1);
        end
        cv[0] = 1'b0;
        tick(2);
        chk("txn wrapped", cnt0, 0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
